pic_sequencer: RTL and testbench

Parametrised, fully synchronous command-and-acknowledge sequencer for the interrupt controller, replacing the strobe-clocked control logic. It decodes ICW1–ICW4 and OCW1/OCW2 writes, owns the in-service and mask registers, and resolves priority among `NUM_IRQ` requests in fixed or rotating order. It also runs the two-pulse INTA handshake that clears the IRR bit, sets the ISR bit and delivers the vector. The block sits between the read/write logic and data bus buffer on one side and the IRR latch on the other.

---
 rtl/pic_sequencer.sv | 152 +++++++++++++++
 tb/tb_pic_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_sequencer.sv
// pic_sequencer: ICW/OCW decode, ISR/IMR ownership, rotating priority and two-pulse INTA handshake
module pic_sequencer #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_stb,
  input  logic               a0,
  input  logic [7:0]         din,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic               inta_n,
  output logic               int_out,
  output logic [7:0]         vector,
  output logic               vector_valid,
  output logic [NUM_IRQ-1:0] irr_clr,
  output logic [NUM_IRQ-1:0] isr,
  output logic [NUM_IRQ-1:0] imr,
  output logic               init_done
);
  localparam int LOG2N = $clog2(NUM_IRQ);
  typedef enum logic [1:0] {IDLE, W_ICW2, W_ICW3, W_ICW4} init_t;
  typedef enum logic {A_IDLE, A_WAIT2} ack_t;
  init_t ist, ist_nx;
  ack_t ast, ast_nx;
  logic [1:0] icw1, icw1_nx;
  logic [7-LOG2N:0] icw2_hi, icw2_hi_nx;
  logic aeoi, aeoi_nx, rot_aeoi, rot_aeoi_nx, done_nx, inta_q, spur, spur_nx;
  logic [LOG2N-1:0] ptr, ptr_nx, id, id_nx, win_id, top_id;
  logic [LOG2N:0] win_rank, top_rank;
  logic [NUM_IRQ-1:0] cand, isr_nx, imr_nx, clr_nx;
  logic win, fall, icw1_wr, ocw, vv_nx;
  logic [7:0] vector_nx;
  assign cand = irr & ~imr;
  assign fall = inta_q & ~inta_n;
  assign icw1_wr = wr_stb & ~a0 & din[4];
  assign ocw = wr_stb & init_done & (ist == IDLE) & ~icw1_wr;
  always_comb begin
    win_id = '0;
    top_id = '0;
    win_rank = (LOG2N+1)'(NUM_IRQ);
    top_rank = (LOG2N+1)'(NUM_IRQ);
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (cand[ptr + LOG2N'(k + 1)]) begin
        win_id = ptr + LOG2N'(k + 1);
        win_rank = (LOG2N+1)'(k);
      end
      if (isr[ptr + LOG2N'(k + 1)]) begin
        top_id = ptr + LOG2N'(k + 1);
        top_rank = (LOG2N+1)'(k);
      end
    end
    win = win_rank < top_rank;
  end
  always_comb begin
    ist_nx = ist;
    ast_nx = ast;
    icw1_nx = icw1;
    icw2_hi_nx = icw2_hi;
    aeoi_nx = aeoi;
    rot_aeoi_nx = rot_aeoi;
    done_nx = init_done;
    ptr_nx = ptr;
    id_nx = id;
    spur_nx = spur;
    isr_nx = isr;
    imr_nx = imr;
    clr_nx = '0;
    vv_nx = 1'b0;
    vector_nx = vector;
    if (icw1_wr) begin
      ist_nx = W_ICW2;
      ast_nx = A_IDLE;
      icw1_nx = din[1:0];
      aeoi_nx = 1'b0;
      done_nx = 1'b0;
      ptr_nx = LOG2N'(NUM_IRQ - 1);
      isr_nx = '0;
      imr_nx = '0;
    end else if (wr_stb && ist != IDLE) begin
      ist_nx = (ist == W_ICW2 && !icw1[1]) ? W_ICW3 : (ist != W_ICW4 && icw1[0]) ? W_ICW4 : IDLE;
      done_nx = (ist_nx == IDLE);
      icw2_hi_nx = (ist == W_ICW2) ? din[7:LOG2N] : icw2_hi;
      aeoi_nx = (ist == W_ICW4) ? din[1] : aeoi;
    end
    if (ocw && a0) imr_nx = din[NUM_IRQ-1:0];
    if (ocw && !a0 && din[4:3] == 2'b00) begin
      if ((din[7:5] == 3'b001 || din[7:5] == 3'b101) && !top_rank[LOG2N]) begin
        isr_nx[top_id] = 1'b0;
        ptr_nx = din[7] ? top_id : ptr;
      end
      if (din[7:5] == 3'b011) isr_nx[din[LOG2N-1:0]] = 1'b0;
      if (din[6:5] == 2'b00) rot_aeoi_nx = din[7];
    end
    if (fall && !icw1_wr && ast == A_IDLE) begin
      ast_nx = A_WAIT2;
      id_nx = win ? win_id : LOG2N'(NUM_IRQ - 1);
      spur_nx = ~win;
      if (win) begin
        isr_nx[win_id] = 1'b1;
        clr_nx[win_id] = 1'b1;
      end
    end
    if (fall && !icw1_wr && ast == A_WAIT2) begin
      ast_nx = A_IDLE;
      vv_nx = 1'b1;
      vector_nx = {icw2_hi, id};
      if (aeoi && !spur) begin
        isr_nx[id] = 1'b0;
        ptr_nx = rot_aeoi ? id : ptr_nx;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ist <= IDLE;
      ast <= A_IDLE;
      icw1 <= '0;
      icw2_hi <= '0;
      aeoi <= 1'b0;
      rot_aeoi <= 1'b0;
      inta_q <= 1'b1;
      spur <= 1'b0;
      ptr <= LOG2N'(NUM_IRQ - 1);
      id <= '0;
      int_out <= 1'b0;
      vector <= '0;
      vector_valid <= 1'b0;
      irr_clr <= '0;
      isr <= '0;
      imr <= '0;
      init_done <= 1'b0;
    end else begin
      ist <= ist_nx;
      ast <= ast_nx;
      icw1 <= icw1_nx;
      icw2_hi <= icw2_hi_nx;
      aeoi <= aeoi_nx;
      rot_aeoi <= rot_aeoi_nx;
      inta_q <= inta_n;
      spur <= spur_nx;
      ptr <= ptr_nx;
      id <= id_nx;
      int_out <= win & done_nx & (ast_nx == A_IDLE);
      vector <= vector_nx;
      vector_valid <= vv_nx;
      irr_clr <= clr_nx;
      isr <= isr_nx;
      imr <= imr_nx;
      init_done <= done_nx;
    end
  end
endmodule

// File: tb/tb_pic_sequencer.sv
// tb_pic_sequencer: directed and random checks of 8- and 4-line sequencers against a behavioural model
module tb_pic_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, wr_stb = 1'b0, a0 = 1'b0, inta_n = 1'b1;
  logic [7:0] din = '0, irr = '0;
  logic io8, vv8, dn8, io4, vv4, dn4;
  logic [7:0] vec8, clr8, isr8, imr8, vec4;
  logic [3:0] clr4, isr4, imr4;
  int total = 0, bad = 0;
  typedef struct packed {
    int n, stage, ptr, id;
    bit done, sngl, ic4, aeoi, rot, wait2, spur, inta_q, vv, int_out;
    bit [7:0] icw2, isr, imr, clr, vector;
  } ms_t;
  ms_t m8, m4;
  pic_sequencer #(.NUM_IRQ(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .a0(a0), .din(din), .irr(irr), .inta_n(inta_n),
    .int_out(io8), .vector(vec8), .vector_valid(vv8), .irr_clr(clr8), .isr(isr8), .imr(imr8), .init_done(dn8)
  );
  pic_sequencer #(.NUM_IRQ(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .a0(a0), .din(din), .irr(irr[3:0]), .inta_n(inta_n),
    .int_out(io4), .vector(vec4), .vector_valid(vv4), .irr_clr(clr4), .isr(isr4), .imr(imr4), .init_done(dn4)
  );
  always #5 clk = ~clk;
  function automatic ms_t mres(int n);
    ms_t r = '0;
    r.n = n;
    r.ptr = n - 1;
    r.inta_q = 1'b1;
    return r;
  endfunction
  function automatic ms_t step(ms_t s, bit wr, bit ad, bit [7:0] d, bit [7:0] irq, bit ia);
    ms_t o = s;
    int n = s.n, best = s.n, bw = 0, topr = s.n, tl = 0, nx = 0;
    bit [7:0] msk = 8'((1 << s.n) - 1);
    bit fall = s.inta_q && !ia;
    bit icw1 = wr && !ad && d[4];
    bit win;
    o.clr = '0;
    o.vv = 1'b0;
    o.inta_q = ia;
    for (int l = 0; l < n; l++) begin
      int rk = (l - s.ptr - 1 + 2 * n) % n;
      if (irq[l] && !s.imr[l] && rk < best) begin best = rk; bw = l; end
      if (s.isr[l] && rk < topr) begin topr = rk; tl = l; end
    end
    win = best < topr;
    if (icw1) begin
      o.stage = 2; o.sngl = d[1]; o.ic4 = d[0]; o.aeoi = 1'b0; o.done = 1'b0;
      o.ptr = n - 1; o.isr = '0; o.imr = '0; o.wait2 = 1'b0;
    end else if (wr && s.stage != 0) begin
      if (s.stage == 2) begin
        o.icw2 = d;
        nx = !s.sngl ? 3 : s.ic4 ? 4 : 0;
      end else if (s.stage == 3) nx = s.ic4 ? 4 : 0;
      else begin
        o.aeoi = d[1];
        nx = 0;
      end
      o.stage = nx;
      o.done = (nx == 0);
    end else if (wr && s.done) begin
      if (ad) o.imr = d & msk;
      else if (d[4:3] == 2'b00) begin
        if ((d[7:5] == 3'd1 || d[7:5] == 3'd5) && topr < n) begin
          o.isr[tl] = 1'b0;
          if (d[7]) o.ptr = tl;
        end
        if (d[7:5] == 3'd3) o.isr[d % n] = 1'b0;
        if (d[7:5] == 3'd4) o.rot = 1'b1;
        if (d[7:5] == 3'd0) o.rot = 1'b0;
      end
    end
    if (fall && !icw1) begin
      if (!s.wait2) begin
        o.wait2 = 1'b1;
        o.spur = !win;
        o.id = win ? bw : n - 1;
        if (win) begin o.isr[bw] = 1'b1; o.clr[bw] = 1'b1; end
      end else begin
        o.wait2 = 1'b0;
        o.vv = 1'b1;
        o.vector = 8'((int'(s.icw2) & ~(n - 1)) | s.id);
        if (s.aeoi && !s.spur) begin
          o.isr[s.id] = 1'b0;
          if (s.rot) o.ptr = s.id;
        end
      end
    end
    o.int_out = win && o.done && !o.wait2;
    return o;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8 = mres(8);
      m4 = mres(4);
    end else begin
      m8 = step(m8, wr_stb, a0, din, irr, inta_n);
      m4 = step(m4, wr_stb, a0, din, {4'b0, irr[3:0]}, inta_n);
    end
  end
  always @(posedge clk) begin
    #2;
    chk("int8", io8, m8.int_out);
    chk("vec8", vec8, m8.vector);
    chk("vv8", vv8, m8.vv);
    chk("clr8", clr8, m8.clr);
    chk("isr8", isr8, m8.isr);
    chk("imr8", imr8, m8.imr);
    chk("done8", dn8, m8.done);
    chk("int4", io4, m4.int_out);
    chk("vec4", vec4, m4.vector);
    chk("vv4", vv4, m4.vv);
    chk("clr4", clr4, m4.clr);
    chk("isr4", isr4, m4.isr);
    chk("imr4", imr4, m4.imr);
    chk("done4", dn4, m4.done);
  end
  task automatic wr(input bit ad, input bit [7:0] d);
    wr_stb = 1'b1;
    a0 = ad;
    din = d;
    @(negedge clk);
    wr_stb = 1'b0;
  endtask
  task automatic ia();
    inta_n = 1'b0;
    @(negedge clk);
    inta_n = 1'b1;
  endtask
  task automatic init(input bit [7:0] i2, input bit [7:0] i4);
    wr(1'b0, 8'h13);
    wr(1'b1, i2);
    wr(1'b1, i4);
  endtask
  initial begin
    m8 = mres(8);
    m4 = mres(4);
    repeat (3) @(negedge clk);
    chk("rst_done", dn8, 0);
    chk("rst_isr", isr8, 0);
    chk("rst_int", io8, 0);
    rst_n = 1'b1;
    @(negedge clk);
    wr(1'b0, 8'h13);
    wr(1'b1, 8'h40);
    chk("done_early", dn8, 0);
    wr(1'b1, 8'h03);
    chk("init_done", dn8, 1);
    irr = 8'h24;
    @(negedge clk);
    chk("basic_int", io8, 1);
    ia();
    chk("basic_clr", clr8, 8'h04);
    chk("basic_isr", isr8, 8'h04);
    chk("basic_drop", io8, 0);
    irr = 8'h20;
    @(negedge clk);
    chk("clr_pulse", clr8, 0);
    ia();
    chk("basic_vec", vec8, 8'h42);
    chk("basic_vv", vv8, 1);
    chk("basic_vec4", vec4, 8'h42);
    chk("aeoi_isr", isr8, 0);
    irr = 8'h00;
    @(negedge clk);
    chk("vv_one", vv8, 0);
    init(8'h40, 8'h01);
    irr = 8'h04;
    @(negedge clk);
    ia();
    irr = 8'h00;
    @(negedge clk);
    ia();
    chk("nest_isr", isr8, 8'h04);
    irr = 8'h20;
    repeat (2) @(negedge clk);
    chk("nest_block", io8, 0);
    irr = 8'h21;
    @(negedge clk);
    chk("nest_pass", io8, 1);
    ia();
    irr = 8'h20;
    @(negedge clk);
    ia();
    chk("nest_isr2", isr8, 8'h05);
    chk("nest_vec", vec8, 8'h40);
    wr(1'b0, 8'h20);
    chk("ns_eoi", isr8, 8'h04);
    wr(1'b0, 8'hA0);
    chk("rot_eoi", isr8, 0);
    irr = 8'h05;
    @(negedge clk);
    ia();
    chk("rot_clr", clr8, 8'h01);
    irr = 8'h04;
    @(negedge clk);
    ia();
    chk("rot_vec", vec8, 8'h40);
    wr(1'b0, 8'h20);
    irr = 8'h0D;
    @(negedge clk);
    ia();
    chk("rot_clr3", clr8, 8'h08);
    irr = 8'h05;
    @(negedge clk);
    ia();
    chk("rot_vec3", vec8, 8'h43);
    wr(1'b0, 8'h20);
    wr(1'b1, 8'hFF);
    irr = 8'h01;
    repeat (2) @(negedge clk);
    chk("mask_int", io8, 0);
    ia();
    chk("spur_clr", clr8, 0);
    @(negedge clk);
    ia();
    chk("spur_vec", vec8, 8'h47);
    chk("spur_vec4", vec4, 8'h43);
    chk("spur_isr", isr8, 0);
    wr(1'b1, 8'h00);
    irr = 8'h02;
    repeat (2) @(negedge clk);
    ia();
    chk("abort_isr", isr8, 8'h02);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_isr0", isr8, 0);
    chk("abort_vec", vec8, 0);
    chk("abort_done", dn8, 0);
    chk("abort_int", io8, 0);
    chk("abort_isr4", isr4, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("noinit_int", io8, 0);
    init(8'h4C, 8'h01);
    @(negedge clk);
    chk("reinit_int", io8, 1);
    ia();
    @(negedge clk);
    ia();
    chk("reinit_vec", vec8, 8'h49);
    chk("reinit_vec4", vec4, 8'h4D);
    for (int c = 0; c < 4000; c++) begin
      int k;
      k = $urandom_range(0, 9);
      wr_stb = ($urandom_range(0, 99) < 8);
      a0 = (k >= 1 && k <= 3);
      din = (k == 0) ? {3'($urandom), 1'b1, 4'($urandom)} :
            (k <= 3) ? 8'($urandom & $urandom) :
            (k <= 8) ? {3'($urandom), 2'b00, 3'($urandom)} : {3'($urandom), 2'b01, 3'($urandom)};
      inta_n = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 5) == 0) irr = 8'($urandom & $urandom);
      rst_n = ($urandom_range(0, 599) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    wr_stb = 1'b0;
    inta_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
